// File: rtl/display_resultado_bcd_pkg.sv
// rtl/display_resultado_bcd_pkg.sv - shared constants for the BCD result display
package display_resultado_bcd_pkg;

    localparam logic [1:0] S_OCIOSO  = 2'd0;
    localparam logic [1:0] S_DESLOCA = 2'd1;
    localparam logic [1:0] S_FIM     = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;

    localparam int unsigned N_ITER = 8;

    // Double-dabble correction applied to each BCD digit before the shift.
    function automatic logic [3:0] ajusta_digito(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/display_resultado_bcd_decodificador_7seg.sv
// rtl/display_resultado_bcd_decodificador_7seg.sv - BCD digit to active-low gfedcba segments
module decodificador_7seg (
    input  logic [3:0] i_digito,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_digito)
            4'd0: o_seg = 7'h40;
            4'd1: o_seg = 7'h79;
            4'd2: o_seg = 7'h24;
            4'd3: o_seg = 7'h30;
            4'd4: o_seg = 7'h19;
            4'd5: o_seg = 7'h12;
            4'd6: o_seg = 7'h02;
            4'd7: o_seg = 7'h78;
            4'd8: o_seg = 7'h00;
            4'd9: o_seg = 7'h10;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/display_resultado_bcd.sv
// rtl/display_resultado_bcd.sv - converts an 8-bit result to signed decimal on four 7-segment digits
module display_resultado_bcd
    import display_resultado_bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] valor,
    input  logic       com_sinal,
    input  logic       erro,
    input  logic       iniciar,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic       ocupado,
    output logic       pronto
);

    logic [1:0]  r_estado;
    logic [19:0] r_desloc;
    logic [3:0]  r_iter;
    logic        r_sinal;
    logic        r_erro;
    logic        r_pronto;
    logic [6:0]  r_hex0;
    logic [6:0]  r_hex1;
    logic [6:0]  r_hex2;
    logic [6:0]  r_hex3;

    logic [7:0]  w_magnitude;
    logic [19:0] w_ajustado;
    logic [3:0]  w_cent;
    logic [3:0]  w_dez;
    logic [3:0]  w_unid;
    logic        w_zero;
    logic [6:0]  w_seg_c;
    logic [6:0]  w_seg_d;
    logic [6:0]  w_seg_u;

    assign w_magnitude = (com_sinal && valor[7]) ? (~valor + 8'd1) : valor;

    // Shift register layout: hundreds[19:16], tens[15:12], units[11:8], binary[7:0].
    assign w_ajustado = {ajusta_digito(r_desloc[19:16]),
                         ajusta_digito(r_desloc[15:12]),
                         ajusta_digito(r_desloc[11:8]),
                         r_desloc[7:0]};

    assign w_cent = r_desloc[19:16];
    assign w_dez  = r_desloc[15:12];
    assign w_unid = r_desloc[11:8];
    assign w_zero = (w_cent == 4'd0) && (w_dez == 4'd0) && (w_unid == 4'd0);

    decodificador_7seg u_dec_cent (.i_digito(w_cent), .o_seg(w_seg_c));
    decodificador_7seg u_dec_dez  (.i_digito(w_dez),  .o_seg(w_seg_d));
    decodificador_7seg u_dec_unid (.i_digito(w_unid), .o_seg(w_seg_u));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_estado <= S_OCIOSO;
            r_desloc <= 20'd0;
            r_iter   <= 4'd0;
            r_sinal  <= 1'b0;
            r_erro   <= 1'b0;
            r_pronto <= 1'b0;
            r_hex0   <= 7'h40;
            r_hex1   <= SEG_BLANK;
            r_hex2   <= SEG_BLANK;
            r_hex3   <= SEG_BLANK;
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                S_OCIOSO: begin
                    if (iniciar) begin
                        r_erro   <= erro;
                        r_sinal  <= com_sinal & valor[7];
                        r_desloc <= {12'd0, w_magnitude};
                        r_iter   <= 4'd0;
                        r_estado <= S_DESLOCA;
                    end
                end
                S_DESLOCA: begin
                    r_desloc <= {w_ajustado[18:0], 1'b0};
                    r_iter   <= r_iter + 4'd1;
                    if (r_iter == 4'(N_ITER - 1)) begin
                        r_estado <= S_FIM;
                    end
                end
                S_FIM: begin
                    r_pronto <= 1'b1;
                    r_estado <= S_OCIOSO;
                    if (r_erro) begin
                        r_hex3 <= SEG_BLANK;
                        r_hex2 <= SEG_E;
                        r_hex1 <= SEG_R;
                        r_hex0 <= SEG_R;
                    end else begin
                        r_hex3 <= (r_sinal && !w_zero) ? SEG_MINUS : SEG_BLANK;
                        r_hex2 <= (w_cent == 4'd0) ? SEG_BLANK : w_seg_c;
                        r_hex1 <= (w_cent == 4'd0 && w_dez == 4'd0) ? SEG_BLANK : w_seg_d;
                        r_hex0 <= w_seg_u;
                    end
                end
                default: r_estado <= S_OCIOSO;
            endcase
        end
    end

    assign ocupado = (r_estado != S_OCIOSO);
    assign pronto  = r_pronto;
    assign hex0    = r_hex0;
    assign hex1    = r_hex1;
    assign hex2    = r_hex2;
    assign hex3    = r_hex3;

endmodule
